// File: rtl/reg_dump_unit.sv
// Register-file dump engine: halts the core, then streams every register
// word (index 0 forced to zero) out over a valid/ready port.
module reg_dump_unit #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic [4:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic [4:0]        dout_idx,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, HALT, READ, SEND, DONE} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  state_t     state;
  logic [4:0] index;

  // Every output is registered; each state transition also loads the output
  // values that the destination state must present.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      index      <= 5'd0;
      halt_req   <= 1'b0;
      rf_raddr   <= 5'd0;
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_idx   <= 5'd0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= HALT;
            index    <= 5'd0;
            halt_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        HALT: begin
          if (halt_ack) begin
            state    <= READ;
            rf_raddr <= index;
          end
        end
        READ: begin
          dout_data  <= (index == 5'd0) ? '0 : rf_rdata;
          dout_idx   <= index;
          dout_last  <= (index == LAST_IDX);
          dout_valid <= 1'b1;
          rf_raddr   <= 5'd0;
          state      <= SEND;
        end
        SEND: begin
          // Word, index and last flag stay frozen until the sink takes them.
          if (dout_ready) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            if (index == LAST_IDX) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              index    <= index + 5'd1;
              rf_raddr <= index + 5'd1;
              state    <= READ;
            end
          end
        end
        DONE: begin
          done     <= 1'b0;
          halt_req <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state      <= IDLE;
          index      <= 5'd0;
          halt_req   <= 1'b0;
          rf_raddr   <= 5'd0;
          dout_valid <= 1'b0;
          dout_last  <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Scoreboard bench for reg_dump_unit: a 32-entry instance exercised through
// all scenarios plus a 4-entry instance for the short-dump boundary.
module tb_reg_dump_unit;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst, start, halt_ack, dout_ready, dead_mode;
  logic        halt_req, dout_valid, dout_last, busy, done;
  logic [4:0]  rf_raddr, dout_idx;
  logic [31:0] rf_rdata, dout_data;

  logic        start4;
  logic        halt_req4, dout_valid4, dout_last4, busy4, done4;
  logic [4:0]  rf_raddr4, dout_idx4;
  logic [31:0] rf_rdata4, dout_data4;

  word_t sb[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    last_xfer_cyc = 0;
  int    done_cnt = 0;
  logic  prev_done = 1'b0;

  always #5 clk = ~clk;

  assign rf_rdata  = dead_mode ? 32'hDEADBEEF : 32'(rf_raddr) * 32'h1111;
  assign rf_rdata4 = 32'(rf_raddr4) * 32'h1111;

  reg_dump_unit dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .halt_ack(halt_ack),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_data(dout_data), .dout_idx(dout_idx),
    .dout_last(dout_last), .busy(busy), .done(done)
  );

  reg_dump_unit #(.NUM_REGS(4), .DATA_W(32)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .halt_req(halt_req4), .halt_ack(1'b1),
    .rf_raddr(rf_raddr4), .rf_rdata(rf_rdata4), .dout_valid(dout_valid4),
    .dout_ready(1'b1), .dout_data(dout_data4), .dout_idx(dout_idx4),
    .dout_last(dout_last4), .busy(busy4), .done(done4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump(input int n);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.idx  = 5'(i);
      w.data = (i == 0) ? 32'h0 : (dead_mode ? 32'hDEADBEEF : 32'(i) * 32'h1111);
      w.last = (i == n - 1);
      sb.push_back(w);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int dc = done_cnt;
    int n = 0;
    while (done_cnt == dc && n < budget) begin
      tick();
      n++;
    end
    check("done_timeout", 32'(done_cnt != dc), 32'd1);
    tick();
  endtask

  task automatic wait_idx(input logic [4:0] idx, input int budget);
    int n = 0;
    while (!(dout_valid && dout_idx == idx) && n < budget) begin
      tick();
      n++;
    end
    check("idx_timeout", 32'(dout_valid && dout_idx == idx), 32'd1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_halt_req"}, 32'(halt_req), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_valid"}, 32'(dout_valid), 32'd0);
    check({tag, "_last"}, 32'(dout_last), 32'd0);
    check({tag, "_data"}, dout_data, 32'd0);
    check({tag, "_idx"}, 32'(dout_idx), 32'd0);
    check({tag, "_raddr"}, 32'(rf_raddr), 32'd0);
  endtask

  // Scoreboard pops on every transfer; done timing and halt release are checked here too.
  always @(negedge clk) begin
    word_t e;
    cyc++;
    if (dout_valid && dout_ready && !rst) begin
      if (sb.size() == 0) begin
        check("unexpected_word", 32'(dout_idx), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("word_idx", 32'(dout_idx), 32'(e.idx));
        check("word_data", dout_data, e.data);
        check("word_last", 32'(dout_last), 32'(e.last));
      end
      last_xfer_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      check("done_gap", 32'(cyc - last_xfer_cyc), 32'd1);
      check("done_busy", 32'(busy), 32'd1);
      check("done_halt_req", 32'(halt_req), 32'd1);
    end
    if (prev_done) begin
      check("post_done_busy", 32'(busy), 32'd0);
      check("post_done_halt_req", 32'(halt_req), 32'd0);
      check("post_done_done", 32'(done), 32'd0);
    end
    prev_done = done;
  end

  initial begin
    logic [31:0] held_data;
    logic [4:0]  held_idx;
    int dc, n, cnt;

    rst = 1'b1; start = 1'b1; start4 = 1'b0; halt_ack = 1'b1;
    dout_ready = 1'b1; dead_mode = 1'b0;
    tick();
    tick();
    check_reset_outs("reset");
    rst = 1'b0; start = 1'b0;
    tick();
    check("rst_start_dropped", 32'(busy), 32'd0);

    // Basic dump with first-word latency.
    push_dump(32);
    pulse_start();
    check("lat_c1_valid", 32'(dout_valid), 32'd0);
    check("lat_c1_halt_req", 32'(halt_req), 32'd1);
    check("lat_c1_busy", 32'(busy), 32'd1);
    tick();
    check("lat_c2_valid", 32'(dout_valid), 32'd0);
    tick();
    check("lat_c3_valid", 32'(dout_valid), 32'd1);
    wait_done(200);
    check("basic_sb_empty", 32'(sb.size()), 32'd0);

    // Delayed halt_ack, then halt_ack drops mid-dump.
    halt_ack = 1'b0;
    push_dump(32);
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      check("halt_wait_valid", 32'(dout_valid), 32'd0);
      check("halt_wait_req", 32'(halt_req), 32'd1);
      tick();
    end
    halt_ack = 1'b1;
    tick();
    check("ack_c1_valid", 32'(dout_valid), 32'd0);
    tick();
    check("ack_c2_valid", 32'(dout_valid), 32'd1);
    halt_ack = 1'b0;
    wait_done(200);
    check("halt_sb_empty", 32'(sb.size()), 32'd0);
    halt_ack = 1'b1;

    // Backpressure on idx 3.
    push_dump(32);
    pulse_start();
    wait_idx(5'd3, 50);
    dout_ready = 1'b0;
    held_data = dout_data;
    held_idx = dout_idx;
    check("bp_data_at_3", held_data, 32'h3333);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid_hold", 32'(dout_valid), 32'd1);
      check("bp_data_hold", dout_data, held_data);
      check("bp_idx_hold", 32'(dout_idx), 32'(held_idx));
    end
    dout_ready = 1'b1;
    wait_done(200);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // x0 masking with constant read data.
    dead_mode = 1'b1;
    push_dump(32);
    pulse_start();
    wait_done(200);
    check("dead_sb_empty", 32'(sb.size()), 32'd0);
    dead_mode = 1'b0;

    // Reset at idx 12, then a fresh full dump.
    push_dump(32);
    pulse_start();
    wait_idx(5'd12, 100);
    dc = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outs("midrst");
    sb.delete();
    tick();
    tick();
    check("midrst_no_done", 32'(done_cnt), 32'(dc));
    push_dump(32);
    pulse_start();
    wait_done(200);
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);

    // Start while busy is ignored.
    dc = done_cnt;
    push_dump(32);
    pulse_start();
    wait_idx(5'd10, 100);
    pulse_start();
    wait_done(200);
    repeat (10) tick();
    check("busy_start_one_done", 32'(done_cnt), 32'(dc + 1));
    check("busy_start_idle", 32'(busy), 32'd0);
    check("busy_start_sb_empty", 32'(sb.size()), 32'd0);

    // Four-entry instance.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    cnt = 0;
    n = 0;
    while (!done4 && n < 40) begin
      if (dout_valid4) begin
        check("n4_idx", 32'(dout_idx4), 32'(cnt));
        check("n4_data", dout_data4, (cnt == 0) ? 32'h0 : 32'(cnt) * 32'h1111);
        check("n4_last", 32'(dout_last4), 32'(cnt == 3));
        cnt++;
      end
      tick();
      n++;
    end
    check("n4_done_seen", 32'(done4), 32'd1);
    check("n4_word_count", 32'(cnt), 32'd4);
    tick();
    check("n4_idle", 32'(busy4), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_dump_unit.md
REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

Interface
REQ-001 Parameter NUM_REGS, default 32: number of register-file entries dumped (2..32).
REQ-002 Parameter DATA_W, default 32: register word width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-006 halt_req  output  1  freezes the core (PC and regfile writes) while high.
REQ-007 halt_ack  input  1  core confirms it is frozen; level signal.
REQ-008 rf_raddr  output  5  register-file read address.
REQ-009 rf_rdata  input  DATA_W  combinational register-file read data for rf_raddr.
REQ-010 dout_valid  output  1  dump word available.
REQ-011 dout_ready  input  1  sink accepts word; transfer when dout_valid && dout_ready on posedge.
REQ-012 dout_data  output  DATA_W  register value.
REQ-013 dout_idx  output  5  register index of dout_data.
REQ-014 dout_last  output  1  high with the word for index NUM_REGS-1.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse after the last word transfers.

Function
REQ-017 FSM states IDLE, HALT, READ, SEND, DONE; encoding is free.
REQ-018 IDLE: start=1 -> HALT next cycle, index counter cleared to 0; start=0 -> stay.
REQ-019 HALT: halt_req=1; halt_ack=1 sampled -> READ; otherwise stay, with no timeout.
REQ-020 halt_req stays high in HALT, READ, SEND and DONE, and drops in the cycle after DONE.
REQ-021 READ: rf_raddr=index; rf_rdata is registered into dout_data at the end of the cycle -> SEND.
REQ-022 dout_data for index 0 is forced to 0 regardless of rf_rdata.
REQ-023 SEND: dout_valid=1, dout_idx=index, dout_last=(index==NUM_REGS-1).
REQ-024 In SEND, dout_data, dout_idx and dout_last are held stable until the transfer; dout_valid never drops without a transfer.
REQ-025 On a transfer with index<NUM_REGS-1: index increments and next state is READ; on a transfer with index==NUM_REGS-1: next state is DONE.
REQ-026 Throughput is one word per 2 cycles at best. With halt_ack already high, the first dout_valid is asserted 3 cycles after the start sample.
REQ-027 DONE: done=1 for exactly one cycle -> IDLE.
REQ-028 start while busy is ignored, with no queuing.
REQ-029 halt_ack dropping after HALT has no effect; the dump continues.
REQ-030 rf_raddr is 0 outside READ; dout_valid, dout_last and done are 0 outside their states.
REQ-031 The index counter never exceeds NUM_REGS-1 and never wraps past it.

Reset
REQ-032 rst=1 at a posedge forces IDLE from any state, including mid-dump.
REQ-033 After that posedge: index=0, halt_req=0, busy=0, done=0, dout_valid=0, dout_last=0, dout_data=0, dout_idx=0, rf_raddr=0.
REQ-034 rst has priority over start; a start in the same cycle as rst is dropped.
REQ-035 A partial dump aborted by reset is not resumed; a new start restarts at index 0.

Verification
REQ-036 Basic dump, halt_ack tied 1, dout_ready tied 1, regfile x[i]=i*16'h1111:
  - start pulse -> 32 words, idx 0..31;
  - word 0 = 0, word 5 = 0x00005555;
  - dout_last only on idx 31;
  - done pulses 1 cycle after the last transfer;
  - busy falls with done.
REQ-037 Halt handshake, halt_ack delayed 7 cycles after halt_req:
  - no dout_valid before halt_ack;
  - first dout_valid 2 cycles after halt_ack is sampled;
  - halt_req stays high until the cycle after done.
REQ-038 Backpressure, dout_ready low for 5 cycles on idx 3:
  - dout_valid, dout_data and dout_idx are held constant those 5 cycles;
  - no word is skipped or duplicated.
REQ-039 x0 masking: rf_rdata returns 0xDEADBEEF for all addresses -> idx 0 = 0, idx 1..31 = 0xDEADBEEF.
REQ-040 Reset mid-dump at idx 12:
  - the cycle after rst, all outputs are at their reset values;
  - a new start dumps from idx 0, 32 words total.
REQ-041 Start while busy: start pulsed at idx 10 -> ignored; exactly one done; 32 words; NUM_REGS=4 run ends at idx 3 with dout_last.
